// File: rtl/video_framer.sv
// Retags a flat 32-bit fragment stream as AXI4-Stream video (tuser = start of frame,
// tlast = end of line) through a small elastic FIFO, with frame-done/count/error status.
module video_framer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  input  logic        err_clear,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = $clog2(H_RES);
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  // Entry layout: {rgb[23:0], sof, eol, eof}
  logic [26:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rdy_en;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_done;
  logic          r_err;
  logic [15:0]   r_frame_count;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [26:0] w_head;
  logic        w_x_last;
  logic        w_pos_last;
  logic        w_early;
  logic        w_sof;
  logic        w_eol;
  logic        w_eof;
  logic        w_err_set;
  logic        w_unused_hi;

  assign w_unused_hi = &{1'b0, s_axis_tdata[31:24]};

  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_push   = s_axis_tvalid & s_axis_tready;
  assign w_pop    = ~w_empty & m_axis_tready;

  assign w_x_last   = (r_x == X_LAST);
  assign w_pos_last = w_x_last & (r_y == Y_LAST);
  assign w_early    = s_axis_tlast & ~w_pos_last;
  assign w_sof      = (r_x == '0) & (r_y == '0);
  assign w_eol      = w_x_last | w_early;
  assign w_eof      = w_pos_last | w_early;
  assign w_err_set  = w_push & (s_axis_tlast ^ w_pos_last);

  // Readiness only comes up on the first clock after reset release.
  assign s_axis_tready = r_rdy_en & ~w_full;
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_head[26:3];
  assign m_axis_tuser  = ~w_empty & w_head[2];
  assign m_axis_tlast  = ~w_empty & w_head[1];

  assign frame_done  = r_done;
  assign frame_err   = r_err;
  assign frame_count = r_frame_count;

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_axis_tdata[23:0], w_sof, w_eol, w_eof};
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pixel position; any end of frame (normal or early) restarts at the origin.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_push) begin
      if (w_eof) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_x_last) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_done <= w_pop & w_head[0];
      if (w_pop && w_head[0]) r_frame_count <= r_frame_count + 16'd1;
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clear) r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_framer.sv
// Bench for video_framer at H_RES=4, V_RES=2: directed and randomized streams checked
// against a position-based framing model and an expected-pixel queue.
module tb_video_framer;
  localparam int H = 4;
  localparam int V = 2;

  logic        aclk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tuser;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        err_clear = 1'b0;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_count;

  video_framer #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(4)) dut (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .err_clear(err_clear), .frame_done(frame_done), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int passed = 0;

  // Expected entries {rgb, sof, eol, eof}; observed pixels {rgb, tuser, tlast}.
  logic [26:0] exp_q[$];
  logic [25:0] got_q[$];
  int          mpos = 0;
  bit          exp_err = 1'b0;
  logic [15:0] exp_frames = '0;
  int          done_pulses = 0;
  bit          stop = 1'b0;

  always @(negedge aclk) begin
    if (resetn) begin
      if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tuser, m_tlast});
      if (frame_done) done_pulses++;
    end
  end

  // Framing by linear position in the frame: position H*V-1 is the only legal tlast.
  function automatic void model_push(input logic [31:0] d, input bit l);
    bit last_pos = (mpos == H*V - 1);
    bit early    = l && !last_pos;
    bit sof      = (mpos == 0);
    bit eol      = ((mpos % H) == H - 1) || early;
    bit eof      = last_pos || early;
    exp_q.push_back({d[23:0], sof, eol, eof});
    if (l != last_pos) exp_err = 1'b1;
    mpos = eof ? 0 : mpos + 1;
  endfunction

  task automatic send(input logic [31:0] d, input bit l);
    bit acc = 1'b0;
    int n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge aclk); acc = s_tready;
      @(posedge aclk); #1; n++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++;
    if (!acc) $display("FAIL send_accept word %h not accepted after %0d cycles", d, n);
    else begin passed++; model_push(d, l); end
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 500) begin @(posedge aclk); #1; n++; end
    repeat (3) begin @(posedge aclk); #1; end
    ok = (n < 500);
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1; @(posedge aclk); #1; err_clear = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    checks++; if (s_tready !== 1'b0) $display("FAIL reset_tready got %b want 0", s_tready); else passed++;
    checks++; if ({m_tvalid, m_tuser, m_tlast} !== 3'b000) $display("FAIL reset_mflags got %b want 000", {m_tvalid, m_tuser, m_tlast}); else passed++;
    checks++; if (m_tdata !== 24'h0) $display("FAIL reset_tdata got %h want 000000", m_tdata); else passed++;
    checks++; if ({frame_done, frame_err} !== 2'b00) $display("FAIL reset_status got %b want 00", {frame_done, frame_err}); else passed++;
    checks++; if (frame_count !== 16'h0) $display("FAIL reset_count got %h want 0000", frame_count); else passed++;
    repeat (2) @(posedge aclk); #1;
    checks++; if (s_tready !== 1'b0) $display("FAIL reset_tready_held got %b want 0", s_tready); else passed++;
    @(negedge aclk); resetn = 1'b1; #1;
    checks++; if (s_tready !== 1'b0) $display("FAIL reset_tready_release got %b want 0", s_tready); else passed++;
    @(posedge aclk); #1;
    checks++; if (s_tready !== 1'b1) $display("FAIL reset_tready_after got %b want 1", s_tready); else passed++;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_empty_valid got %b want 0", m_tvalid); else passed++;
  endtask

  task automatic test_nominal();
    bit ok; int n_eof = 0; logic [26:0] e; logic [25:0] g; longint t0;
    m_tready = 1'b1; done_pulses = 0;
    send(32'h1, 1'b0);
    checks++; if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, 24'h1, 1'b1}) $display("FAIL nominal_latency got v=%b d=%h u=%b want v=1 d=000001 u=1", m_tvalid, m_tdata, m_tuser); else passed++;
    t0 = $time;
    for (int i = 2; i <= 8; i++) send(32'(i), i == 8);
    checks++; if (($time - t0) != 70) $display("FAIL nominal_throughput got %0d time units want 70", $time - t0); else passed++;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL nominal_drain got %0d pixels want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (e[0]) begin n_eof++; exp_frames++; end
      checks++; if (g !== e[26:1]) $display("FAIL nominal_pixel got %h want %h", g, e[26:1]); else passed++;
    end
    checks++; if (got_q.size() != 0) $display("FAIL nominal_extra got %0d extra pixels want 0", got_q.size()); else passed++;
    checks++; if (done_pulses != n_eof) $display("FAIL nominal_done got %0d pulses want %0d", done_pulses, n_eof); else passed++;
    checks++; if (frame_count !== exp_frames) $display("FAIL nominal_count got %h want %h", frame_count, exp_frames); else passed++;
    checks++; if (frame_err !== exp_err) $display("FAIL nominal_err got %b want %b", frame_err, exp_err); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok; int n_eof = 0; logic [26:0] e; logic [25:0] g;
    logic [31:0] w [8]; logic [26:0] held;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    m_tready = 1'b0; done_pulses = 0;
    for (int i = 0; i < 4; i++) send(w[i], 1'b0);
    checks++; if (s_tready !== 1'b0) $display("FAIL bp_full_tready got %b want 0", s_tready); else passed++;
    held = {m_tvalid, m_tdata, m_tuser, m_tlast};
    checks++; if (held !== {1'b1, w[0][23:0], 1'b1, 1'b0}) $display("FAIL bp_head got %h want %h", held, {1'b1, w[0][23:0], 1'b1, 1'b0}); else passed++;
    s_tdata = w[4]; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      checks++; if ({m_tvalid, m_tdata, m_tuser, m_tlast, s_tready} !== {held, 1'b0}) $display("FAIL bp_hold got %h want %h", {m_tvalid, m_tdata, m_tuser, m_tlast, s_tready}, {held, 1'b0}); else passed++;
      @(posedge aclk); #1;
    end
    m_tready = 1'b1;
    @(negedge aclk);
    checks++; if (s_tready !== 1'b0) $display("FAIL bp_release_same got %b want 0", s_tready); else passed++;
    @(posedge aclk); #1;
    checks++; if (s_tready !== 1'b1) $display("FAIL bp_release_next got %b want 1", s_tready); else passed++;
    for (int i = 4; i < 8; i++) send(w[i], i == 7);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL bp_drain got %0d pixels want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (e[0]) begin n_eof++; exp_frames++; end
      checks++; if (g !== e[26:1]) $display("FAIL bp_pixel got %h want %h", g, e[26:1]); else passed++;
    end
    checks++; if (got_q.size() != 0) $display("FAIL bp_extra got %0d extra pixels want 0", got_q.size()); else passed++;
    checks++; if (done_pulses != n_eof) $display("FAIL bp_done got %0d pulses want %0d", done_pulses, n_eof); else passed++;
    checks++; if (frame_count !== exp_frames) $display("FAIL bp_count got %h want %h", frame_count, exp_frames); else passed++;
  endtask

  task automatic test_early_tlast();
    bit ok; int n_eof = 0; logic [26:0] e; logic [25:0] g;
    m_tready = 1'b1; done_pulses = 0;
    for (int i = 0; i < 3; i++) send($urandom, i == 2);
    for (int i = 0; i < 8; i++) send($urandom, i == 7);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL early_drain got %0d pixels want %0d", got_q.size(), exp_q.size()); else passed++;
    checks++; if (got_q.size() < 4 || got_q[2][0] !== 1'b1 || got_q[3][1] !== 1'b1) $display("FAIL early_tags got size=%0d want pixel3 tlast=1 pixel4 tuser=1", got_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (e[0]) begin n_eof++; exp_frames++; end
      checks++; if (g !== e[26:1]) $display("FAIL early_pixel got %h want %h", g, e[26:1]); else passed++;
    end
    checks++; if (done_pulses != n_eof) $display("FAIL early_done got %0d pulses want %0d", done_pulses, n_eof); else passed++;
    checks++; if (frame_count !== exp_frames) $display("FAIL early_count got %h want %h", frame_count, exp_frames); else passed++;
    checks++; if (frame_err !== 1'b1) $display("FAIL early_err got %b want 1", frame_err); else passed++;
    pulse_err_clear();
    checks++; if (frame_err !== 1'b0) $display("FAIL early_err_clear got %b want 0", frame_err); else passed++;
  endtask

  task automatic test_missing_tlast();
    bit ok; int n_eof = 0; logic [26:0] e; logic [25:0] g;
    m_tready = 1'b1; done_pulses = 0;
    for (int i = 0; i < 12; i++) send($urandom, 1'b0);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL missing_drain got %0d pixels want %0d", got_q.size(), exp_q.size()); else passed++;
    checks++; if (got_q.size() < 12 || got_q[7][0] !== 1'b1 || got_q[8][1] !== 1'b1 || got_q[11][0] !== 1'b1) $display("FAIL missing_tags got size=%0d want p8 tlast p9 tuser p12 tlast", got_q.size()); else passed++;
    checks++; if (frame_err !== 1'b1) $display("FAIL missing_err got %b want 1", frame_err); else passed++;
    pulse_err_clear();
    checks++; if (frame_err !== 1'b0) $display("FAIL missing_err_clear got %b want 0", frame_err); else passed++;
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    err_clear = 1'b1;
    send($urandom, 1'b0);
    err_clear = 1'b0;
    checks++; if (frame_err !== exp_err) $display("FAIL missing_set_wins got %b want %b", frame_err, exp_err); else passed++;
    wait_drain(ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (e[0]) begin n_eof++; exp_frames++; end
      checks++; if (g !== e[26:1]) $display("FAIL missing_pixel got %h want %h", g, e[26:1]); else passed++;
    end
    checks++; if (done_pulses != n_eof) $display("FAIL missing_done got %0d pulses want %0d", done_pulses, n_eof); else passed++;
    checks++; if (frame_count !== exp_frames) $display("FAIL missing_count got %h want %h", frame_count, exp_frames); else passed++;
    pulse_err_clear();
  endtask

  task automatic test_random();
    bit ok; int n_eof = 0; logic [26:0] e; logic [25:0] g;
    done_pulses = 0; stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge aclk); #1; end
          send($urandom, $urandom_range(0, 7) == 0);
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin @(posedge aclk); #1; m_tready = ($urandom_range(0, 3) != 0); end
      end
      begin
        bit hold = 1'b0; logic [26:0] held = '0;
        while (!stop) begin
          @(negedge aclk);
          if (hold) begin
            checks++; if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== held) $display("FAIL rand_stable got %h want %h", {m_tvalid, m_tdata, m_tuser, m_tlast}, held); else passed++;
          end
          hold = m_tvalid && !m_tready;
          held = {m_tvalid, m_tdata, m_tuser, m_tlast};
        end
      end
    join
    m_tready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL rand_drain got %0d pixels want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (e[0]) begin n_eof++; exp_frames++; end
      checks++; if (g !== e[26:1]) $display("FAIL rand_pixel got %h want %h", g, e[26:1]); else passed++;
    end
    checks++; if (got_q.size() != 0) $display("FAIL rand_extra got %0d extra pixels want 0", got_q.size()); else passed++;
    checks++; if (done_pulses != n_eof) $display("FAIL rand_done got %0d pulses want %0d", done_pulses, n_eof); else passed++;
    checks++; if (frame_count !== exp_frames) $display("FAIL rand_count got %h want %h", frame_count, exp_frames); else passed++;
    checks++; if (frame_err !== exp_err) $display("FAIL rand_err got %b want %b", frame_err, exp_err); else passed++;
  endtask

  task automatic test_reset_midframe();
    bit ok; int n_eof = 0; logic [26:0] e; logic [25:0] g;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    m_tready = 1'b0;
    for (int i = 0; i < 2; i++) send($urandom, 1'b0);
    checks++; if (m_tvalid !== 1'b1) $display("FAIL rst_pre_valid got %b want 1", m_tvalid); else passed++;
    #2 resetn = 1'b0;
    #1;
    checks++; if ({m_tvalid, m_tuser, m_tlast, s_tready} !== 4'b0000) $display("FAIL rst_async_flags got %b want 0000", {m_tvalid, m_tuser, m_tlast, s_tready}); else passed++;
    checks++; if ({m_tdata, frame_done, frame_err, frame_count} !== 42'h0) $display("FAIL rst_async_data got d=%h done=%b err=%b cnt=%h want all 0", m_tdata, frame_done, frame_err, frame_count); else passed++;
    exp_q.delete(); got_q.delete();
    mpos = 0; exp_err = 1'b0; exp_frames = '0; done_pulses = 0;
    @(negedge aclk); resetn = 1'b1;
    @(posedge aclk); #1;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) send($urandom, i == 7);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL rst_drain got %0d pixels want %0d", got_q.size(), exp_q.size()); else passed++;
    checks++; if (got_q.size() < 1 || got_q[0][1] !== 1'b1) $display("FAIL rst_first_sof got size=%0d want first tuser=1", got_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (e[0]) begin n_eof++; exp_frames++; end
      checks++; if (g !== e[26:1]) $display("FAIL rst_pixel got %h want %h", g, e[26:1]); else passed++;
    end
    checks++; if (frame_count !== 16'd1) $display("FAIL rst_count got %h want 0001", frame_count); else passed++;
    checks++; if (done_pulses != n_eof) $display("FAIL rst_done got %0d pulses want %0d", done_pulses, n_eof); else passed++;
  endtask

  task automatic test_count_wrap();
    bit ok; int n_eof = 0; logic [26:0] e; logic [25:0] g;
    m_tready = 1'b1; done_pulses = 0;
    force dut.r_frame_count = 16'hFFFF;
    @(posedge aclk); #1;
    release dut.r_frame_count;
    exp_frames = 16'hFFFF;
    checks++; if (frame_count !== 16'hFFFF) $display("FAIL wrap_forced got %h want ffff", frame_count); else passed++;
    for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
    wait_drain(ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (e[0]) begin n_eof++; exp_frames++; end
      checks++; if (g !== e[26:1]) $display("FAIL wrap_pixel got %h want %h", g, e[26:1]); else passed++;
    end
    checks++; if (frame_count !== exp_frames) $display("FAIL wrap_count got %h want %h", frame_count, exp_frames); else passed++;
    checks++; if (done_pulses != n_eof) $display("FAIL wrap_done got %0d pulses want %0d", done_pulses, n_eof); else passed++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_tlast();
    test_missing_tlast();
    test_random();
    test_reset_midframe();
    test_count_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish: %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
